// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the write-back stage
package wb_pkg;

  // Write-data source select
  localparam logic [1:0] WB_SEL_NONE = 2'b00;
  localparam logic [1:0] WB_SEL_VALE = 2'b01;
  localparam logic [1:0] WB_SEL_VALP = 2'b10;
  localparam logic [1:0] WB_SEL_VALM = 2'b11;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - sub-word load sign/zero extension selected by funct3
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  // Size casts of signed slices give sign extension; unsigned slices zero-extend.
  // LW at WIDTH=32 collapses to the identity.
  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = WIDTH'($signed(data_i[7:0]));
      F3_LH:   data_o = WIDTH'($signed(data_i[15:0]));
      F3_LW:   data_o = WIDTH'($signed(data_i[31:0]));
      F3_LBU:  data_o = WIDTH'(data_i[7:0]);
      F3_LHU:  data_o = WIDTH'(data_i[15:0]);
      F3_LWU:  data_o = WIDTH'(data_i[31:0]);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - registered W stage with retire counter and ebreak halt
module writeback_stage
  import wb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_valid_i,
  output logic                 m_ready_o,
  input  logic [31:0]          m_pc_i,
  input  logic [31:0]          m_instr_i,
  input  logic                 m_reg_wen_i,
  input  logic [4:0]           m_rd_i,
  input  logic [1:0]           m_valD_sel_i,
  input  logic [2:0]           m_load_funct3_i,
  input  logic [WIDTH-1:0]     m_alu_result_i,
  input  logic [WIDTH-1:0]     m_mem_data_i,
  input  logic                 resume_i,
  output logic                 wb_reg_wen_o,
  output logic [4:0]           wb_rd_o,
  output logic [WIDTH-1:0]     wb_rd_write_data_o,
  output logic                 retire_valid_o,
  output logic [31:0]          retire_pc_o,
  output logic                 halt_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  logic                 w_valid_q;
  logic [31:0]          w_pc_q;
  logic [31:0]          w_instr_q;
  logic                 w_wen_q;
  logic [4:0]           w_rd_q;
  logic [1:0]           w_sel_q;
  logic [2:0]           w_funct3_q;
  logic [WIDTH-1:0]     w_alu_q;
  logic [WIDTH-1:0]     w_mem_q;
  wb_state_e            state_q;
  logic                 halt_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [CNT_WIDTH-1:0] instret_d;

  logic                 w_is_ebreak;
  logic                 ebreak_retire;
  logic                 accept;
  logic [31:0]          pc_plus4;
  logic [WIDTH-1:0]     load_data;
  logic [WIDTH-1:0]     wdata;

  assign w_is_ebreak   = (w_instr_q == EBREAK_INSTR);
  assign ebreak_retire = w_valid_q && w_is_ebreak;
  // The ebreak itself is accepted, but nothing may enter behind it.
  assign m_ready_o     = (state_q == ST_RUN) && !ebreak_retire;
  assign accept        = m_valid_i && m_ready_o;
  assign pc_plus4      = w_pc_q + 32'd4;
  assign instret_d     = instret_q + CNT_WIDTH'(1);

  wb_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .funct3_i (w_funct3_q),
    .data_i   (w_mem_q),
    .data_o   (load_data)
  );

  // Select register-file write data from the W entry
  always_comb begin
    wdata = '0;
    case (w_sel_q)
      WB_SEL_VALE: wdata = w_alu_q;
      WB_SEL_VALP: wdata = WIDTH'(pc_plus4);
      WB_SEL_VALM: wdata = load_data;
      default:     wdata = '0;
    endcase
  end

  // W register: one entry, lives for exactly one cycle after capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_q  <= 1'b0;
      w_pc_q     <= '0;
      w_instr_q  <= '0;
      w_wen_q    <= 1'b0;
      w_rd_q     <= '0;
      w_sel_q    <= WB_SEL_NONE;
      w_funct3_q <= '0;
      w_alu_q    <= '0;
      w_mem_q    <= '0;
    end else begin
      w_valid_q <= accept;
      if (accept) begin
        w_pc_q     <= m_pc_i;
        w_instr_q  <= m_instr_i;
        w_wen_q    <= m_reg_wen_i;
        w_rd_q     <= m_rd_i;
        w_sel_q    <= m_valD_sel_i;
        w_funct3_q <= m_load_funct3_i;
        w_alu_q    <= m_alu_result_i;
        w_mem_q    <= m_mem_data_i;
      end
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (w_valid_q) begin
      instret_q <= instret_d;
    end
  end

  // Halt FSM: enter HALTED as a valid ebreak retires, leave on resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ebreak_retire) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume_i) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign retire_valid_o     = w_valid_q;
  assign retire_pc_o        = w_pc_q;
  assign wb_rd_o            = w_rd_q;
  // An ebreak never writes the register file, whatever its wen bit says.
  assign wb_reg_wen_o       = w_valid_q && w_wen_q && (w_rd_q != 5'd0) && !w_is_ebreak;
  assign wb_rd_write_data_o = wdata;
  assign halt_o             = halt_q;
  assign instret_o          = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk;
  logic        rst_n;
  logic        m_valid_i;
  logic [31:0] m_pc_i;
  logic [31:0] m_instr_i;
  logic        m_reg_wen_i;
  logic [4:0]  m_rd_i;
  logic [1:0]  m_valD_sel_i;
  logic [2:0]  m_load_funct3_i;
  logic [31:0] alu32, mem32;
  logic [63:0] alu64, mem64;
  logic        resume_i;

  logic        ready32, wen32, rv32, halt32;
  logic [4:0]  rd32;
  logic [31:0] data32, rpc32;
  logic [63:0] cnt32;

  logic        ready64, wen64, rv64, halt64;
  logic [4:0]  rd64;
  logic [63:0] data64;
  logic [31:0] rpc64;
  logic [63:0] cnt64;

  int pass_cnt = 0;
  int total_cnt = 0;

  writeback_stage #(.WIDTH(32), .CNT_WIDTH(64)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .m_valid_i(m_valid_i), .m_ready_o(ready32),
    .m_pc_i(m_pc_i), .m_instr_i(m_instr_i), .m_reg_wen_i(m_reg_wen_i), .m_rd_i(m_rd_i),
    .m_valD_sel_i(m_valD_sel_i), .m_load_funct3_i(m_load_funct3_i),
    .m_alu_result_i(alu32), .m_mem_data_i(mem32), .resume_i(resume_i),
    .wb_reg_wen_o(wen32), .wb_rd_o(rd32), .wb_rd_write_data_o(data32),
    .retire_valid_o(rv32), .retire_pc_o(rpc32), .halt_o(halt32), .instret_o(cnt32)
  );

  writeback_stage #(.WIDTH(64), .CNT_WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .m_valid_i(m_valid_i), .m_ready_o(ready64),
    .m_pc_i(m_pc_i), .m_instr_i(m_instr_i), .m_reg_wen_i(m_reg_wen_i), .m_rd_i(m_rd_i),
    .m_valD_sel_i(m_valD_sel_i), .m_load_funct3_i(m_load_funct3_i),
    .m_alu_result_i(alu64), .m_mem_data_i(mem64), .resume_i(resume_i),
    .wb_reg_wen_o(wen64), .wb_rd_o(rd64), .wb_rd_write_data_o(data64),
    .retire_valid_o(rv64), .retire_pc_o(rpc64), .halt_o(halt64), .instret_o(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for one edge, then drop valid; sampling point is #1 after the edge
  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic wen,
                      input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [63:0] alu, input logic [63:0] mem);
    m_valid_i = 1'b1; m_pc_i = pc; m_instr_i = instr; m_reg_wen_i = wen; m_rd_i = rd;
    m_valD_sel_i = sel; m_load_funct3_i = f3;
    alu32 = alu[31:0]; mem32 = mem[31:0]; alu64 = alu; mem64 = mem;
    @(posedge clk); #1;
    m_valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (ready32 !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL reset_retire got %b exp 0", rv32); else pass_cnt++;
    total_cnt++; if (wen32 !== 1'b0) $display("FAIL reset_wen got %b exp 0", wen32); else pass_cnt++;
    total_cnt++; if (halt32 !== 1'b0) $display("FAIL reset_halt got %b exp 0", halt32); else pass_cnt++;
    total_cnt++; if (cnt32 !== 64'd0) $display("FAIL reset_instret got %0d exp 0", cnt32); else pass_cnt++;
    total_cnt++; if (data32 !== 32'd0) $display("FAIL reset_data got %h exp 0", data32); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    send(32'h100, ADDI, 1'b1, 5'd5, 2'b01, 3'd0, 64'hDEADBEEF, 64'd0);
    total_cnt++; if (wen32 !== 1'b1) $display("FAIL alu_wen got %b exp 1", wen32); else pass_cnt++;
    total_cnt++; if (rd32 !== 5'd5) $display("FAIL alu_rd got %0d exp 5", rd32); else pass_cnt++;
    total_cnt++; if (data32 !== 32'hDEADBEEF) $display("FAIL alu_data got %h exp deadbeef", data32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b1) $display("FAIL alu_retire got %b exp 1", rv32); else pass_cnt++;
    total_cnt++; if (rpc32 !== 32'h100) $display("FAIL alu_pc got %h exp 100", rpc32); else pass_cnt++;
    total_cnt++; if (cnt32 !== 64'd0) $display("FAIL alu_instret_before got %0d exp 0", cnt32); else pass_cnt++;
    idle_cycle();
    total_cnt++; if (cnt32 !== 64'd1) $display("FAIL alu_instret_after got %0d exp 1", cnt32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL alu_retire_drop got %b exp 0", rv32); else pass_cnt++;
  endtask

  task automatic test_rd0_none();
    send(32'h104, ADDI, 1'b1, 5'd0, 2'b01, 3'd0, 64'h1234, 64'd0);
    total_cnt++; if (wen32 !== 1'b0) $display("FAIL rd0_wen got %b exp 0", wen32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b1) $display("FAIL rd0_retire got %b exp 1", rv32); else pass_cnt++;
    send(32'h108, ADDI, 1'b1, 5'd3, 2'b00, 3'd0, 64'h1234, 64'h5678);
    total_cnt++; if (data32 !== 32'd0) $display("FAIL none_data got %h exp 0", data32); else pass_cnt++;
    total_cnt++; if (wen32 !== 1'b1) $display("FAIL none_wen got %b exp 1", wen32); else pass_cnt++;
    idle_cycle();
    total_cnt++; if (cnt32 !== 64'd3) $display("FAIL rd0_instret got %0d exp 3", cnt32); else pass_cnt++;
  endtask

  task automatic test_jal();
    send(32'hFFFFFFFC, ADDI, 1'b1, 5'd1, 2'b10, 3'd0, 64'd0, 64'd0);
    total_cnt++; if (data32 !== 32'd0) $display("FAIL jal_wrap got %h exp 0", data32); else pass_cnt++;
    total_cnt++; if (data64 !== 64'd0) $display("FAIL jal_wrap64 got %h exp 0", data64); else pass_cnt++;
    send(32'h80000000, ADDI, 1'b1, 5'd1, 2'b10, 3'd0, 64'd0, 64'd0);
    total_cnt++; if (data32 !== 32'h80000004) $display("FAIL jal_link got %h exp 80000004", data32); else pass_cnt++;
    total_cnt++; if (data64 !== 64'h80000004) $display("FAIL jal_link64 got %h exp 80000004", data64); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_loads();
    logic [2:0]  f3_tab  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exp_tab [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
    for (int i = 0; i < 4; i++) begin
      send(32'h200, ADDI, 1'b1, 5'd7, 2'b11, f3_tab[i], 64'd0, 64'h000080F0);
      total_cnt++;
      if (data32 !== exp_tab[i]) $display("FAIL load_f3_%0d got %h exp %h", f3_tab[i], data32, exp_tab[i]);
      else pass_cnt++;
    end
    send(32'h204, ADDI, 1'b1, 5'd7, 2'b11, 3'b010, 64'd0, 64'h0000_0000_8000_0000);
    total_cnt++; if (data64 !== 64'hFFFF_FFFF_8000_0000) $display("FAIL lw64 got %h exp ffffffff80000000", data64); else pass_cnt++;
    total_cnt++; if (data32 !== 32'h8000_0000) $display("FAIL lw32 got %h exp 80000000", data32); else pass_cnt++;
    send(32'h208, ADDI, 1'b1, 5'd7, 2'b11, 3'b110, 64'd0, 64'h0000_0000_8000_0000);
    total_cnt++; if (data64 !== 64'h0000_0000_8000_0000) $display("FAIL lwu64 got %h exp 80000000", data64); else pass_cnt++;
    send(32'h20C, ADDI, 1'b1, 5'd7, 2'b11, 3'b011, 64'd0, 64'h8765_4321_0000_00F0);
    total_cnt++; if (data64 !== 64'h8765_4321_0000_00F0) $display("FAIL ld64 got %h exp 87654321000000f0", data64); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_ebreak_halt();
    pulse_reset();
    send(32'h300, ADDI, 1'b1, 5'd1, 2'b01, 3'd0, 64'd1, 64'd0);
    send(32'h304, EBREAK, 1'b1, 5'd2, 2'b01, 3'd0, 64'd9, 64'd0);
    total_cnt++; if (ready32 !== 1'b0) $display("FAIL ebreak_ready got %b exp 0", ready32); else pass_cnt++;
    total_cnt++; if (wen32 !== 1'b0) $display("FAIL ebreak_wen got %b exp 0", wen32); else pass_cnt++;
    total_cnt++; if (halt32 !== 1'b0) $display("FAIL ebreak_halt_early got %b exp 0", halt32); else pass_cnt++;
    // Third instruction waits at the input while the ebreak retires
    m_valid_i = 1'b1; m_pc_i = 32'h308; m_instr_i = ADDI; m_rd_i = 5'd3; m_valD_sel_i = 2'b01;
    alu32 = 32'h33; alu64 = 64'h33;
    idle_cycle();
    total_cnt++; if (halt32 !== 1'b1) $display("FAIL halt_set got %b exp 1", halt32); else pass_cnt++;
    total_cnt++; if (ready32 !== 1'b0) $display("FAIL halt_ready got %b exp 0", ready32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL halt_retire got %b exp 0", rv32); else pass_cnt++;
    total_cnt++; if (cnt32 !== 64'd2) $display("FAIL halt_instret got %0d exp 2", cnt32); else pass_cnt++;
    idle_cycle();
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL halt_hold got %b exp 0", rv32); else pass_cnt++;
    resume_i = 1'b1;
    idle_cycle();
    resume_i = 1'b0;
    total_cnt++; if (halt32 !== 1'b0) $display("FAIL resume_halt got %b exp 0", halt32); else pass_cnt++;
    total_cnt++; if (ready32 !== 1'b1) $display("FAIL resume_ready got %b exp 1", ready32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL resume_retire got %b exp 0", rv32); else pass_cnt++;
    idle_cycle();
    m_valid_i = 1'b0;
    total_cnt++; if (rv32 !== 1'b1) $display("FAIL held_retire got %b exp 1", rv32); else pass_cnt++;
    total_cnt++; if (rpc32 !== 32'h308) $display("FAIL held_pc got %h exp 308", rpc32); else pass_cnt++;
    total_cnt++; if (data32 !== 32'h33) $display("FAIL held_data got %h exp 33", data32); else pass_cnt++;
    idle_cycle();
    total_cnt++; if (cnt32 !== 64'd3) $display("FAIL held_instret got %0d exp 3", cnt32); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      send(32'h400 + 32'(4 * i), ADDI, 1'b1, 5'd4, 2'b01, 3'd0, 64'(i), 64'd0);
    end
    total_cnt++; if (cnt32 !== 64'd7) $display("FAIL pre_reset_instret got %0d exp 7", cnt32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b1) $display("FAIL pre_reset_retire got %b exp 1", rv32); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (cnt32 !== 64'd0) $display("FAIL async_instret got %0d exp 0", cnt32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b0) $display("FAIL async_retire got %b exp 0", rv32); else pass_cnt++;
    total_cnt++; if (wen32 !== 1'b0) $display("FAIL async_wen got %b exp 0", wen32); else pass_cnt++;
    total_cnt++; if (rpc32 !== 32'd0) $display("FAIL async_pc got %h exp 0", rpc32); else pass_cnt++;
    total_cnt++; if (data32 !== 32'd0) $display("FAIL async_data got %h exp 0", data32); else pass_cnt++;
    total_cnt++; if (ready32 !== 1'b1) $display("FAIL async_ready got %b exp 1", ready32); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    send(32'h500, ADDI, 1'b1, 5'd6, 2'b01, 3'd0, 64'h66, 64'd0);
    total_cnt++; if (cnt32 !== 64'd0) $display("FAIL post_reset_before got %0d exp 0", cnt32); else pass_cnt++;
    total_cnt++; if (rv32 !== 1'b1) $display("FAIL post_reset_retire got %b exp 1", rv32); else pass_cnt++;
    idle_cycle();
    total_cnt++; if (cnt32 !== 64'd1) $display("FAIL post_reset_after got %0d exp 1", cnt32); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; m_valid_i = 1'b0; m_pc_i = '0; m_instr_i = '0; m_reg_wen_i = 1'b0;
    m_rd_i = '0; m_valD_sel_i = '0; m_load_funct3_i = '0;
    alu32 = '0; mem32 = '0; alu64 = '0; mem64 = '0; resume_i = 1'b0;
    test_reset();
    test_alu();
    test_rd0_none();
    test_jal();
    test_loads();
    test_ebreak_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised successor to the combinational write-back block: a registered W stage between the memory stage and the register file.
- Adds a valid/ready handshake, sub-word load extension, a retire port with a 64-bit retired-instruction counter, and an ebreak halt state machine.
- Consumes memory-stage outputs; drives the register-file write port and the retire/halt signals seen by the sim harness.

Parameters:
- WIDTH, 32, datapath width. Legal values are 32 or 64.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- m_valid_i  in  1  memory stage presents an instruction.
- m_ready_o  out  1  W stage can accept.
- m_pc_i  in  32  instruction PC.
- m_instr_i  in  32  raw instruction.
- m_reg_wen_i  in  1  instruction writes rd.
- m_rd_i  in  5  destination register.
- m_valD_sel_i  in  2  write-data source select.
- m_load_funct3_i  in  3  load funct3; used only when select is valM.
- m_alu_result_i  in  WIDTH  valE.
- m_mem_data_i  in  WIDTH  valM, already right-aligned.
- resume_i  in  1  leave the HALTED state.
- wb_reg_wen_o  out  1  register-file write enable.
- wb_rd_o  out  5  register-file write address.
- wb_rd_write_data_o  out  WIDTH  register-file write data.
- retire_valid_o  out  1  one instruction retires this cycle.
- retire_pc_o  out  32  PC of the retiring instruction.
- halt_o  out  1  core halted on ebreak.
- instret_o  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (rst_n=0, async): W register invalid, all of its fields 0, state RUN, instret_o=0. Consequently all outputs are 0 during reset, except m_ready_o=1.
- W register holds one entry. Capture happens on m_valid_i && m_ready_o.
- m_ready_o = (state==RUN) && !(w_valid && w_is_ebreak). The ebreak itself is accepted; nothing is accepted behind it.
- Latency: an instruction accepted at edge N drives outputs during cycle N..N+1 and retires at edge N+1. Each entry occupies W for exactly one cycle; there is no back-pressure from downstream.
- Outputs are combinational from the W register:
  - retire_valid_o = w_valid.
  - retire_pc_o = w_pc.
  - wb_rd_o = w_rd.
  - wb_reg_wen_o = w_valid && w_wen && (w_rd != 0).
- Write data by valD_sel:
  - NONE: 0.
  - VALE: alu_result.
  - VALP: pc+4, zero-extended to WIDTH; wraps modulo 2^32.
  - VALM: load extension by funct3.
- Load extension (funct3):
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: sign-extend [31:0]. This is identity when WIDTH=32.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 110 LWU: zero-extend [31:0].
  - 011 LD: raw data.
  - 111: raw data.
- instret_o increments by 1 at each edge where w_valid=1, ebreak included. It wraps from all-ones to 0.
- w_is_ebreak: w_instr == 32'h00100073.
- FSM, RUN -> HALTED: at the edge where a valid ebreak retires. The ebreak does not write the register file regardless of m_reg_wen_i.
- FSM, HALTED:
  - halt_o=1, m_ready_o=0, w_valid=0.
  - On resume_i=1: next state RUN, halt_o drops at that edge.
  - resume_i in RUN is ignored.
- Simultaneous events:
  - Ebreak retiring and a new m_valid_i in the same cycle: the new instruction is not accepted.
  - Reset while HALTED or with W valid: immediate return to reset values, no retire counted.

Optional Feature:
- Macro WB_DPI_EBREAK_EN.
- Defined: import DPI-C dpi_ebreak(input int pc) and call it once with w_pc on the clock edge of the RUN->HALTED transition.
- Undefined: no DPI import. Halt is signalled only through halt_o.
- Cycle behaviour is identical in both builds.

Decomposition:
- Package wb_pkg:
  - valD_sel localparams: WB_SEL_NONE=2'b00, WB_SEL_VALE=2'b01, WB_SEL_VALP=2'b10, WB_SEL_VALM=2'b11.
  - Load funct3 constants.
  - EBREAK_INSTR=32'h00100073.
  - Typedef for the state enum {RUN, HALTED}.
- Sub-module wb_load_ext: combinational funct3 + data -> extended data, parametrised by WIDTH.

Test Plan:
- ALU writeback: accept {rd=5, sel=VALE, alu=32'hDEADBEEF} -> next cycle wb_reg_wen_o=1, wb_rd_o=5, data=32'hDEADBEEF, instret_o 0->1 after the edge.
- rd=0 and sel=NONE: rd=0 with wen=1 -> wb_reg_wen_o=0, retire_valid_o=1. Separately, sel=NONE gives data 0.
- JAL link: sel=VALP, pc=32'hFFFFFFFC -> data=0 (wrap). With pc=32'h80000000 -> data=32'h80000004.
- Loads: mem=32'h0000_80F0:
  - LB -> 32'hFFFFFFF0.
  - LBU -> 32'h000000F0.
  - LH -> 32'hFFFF80F0.
  - LHU -> 32'h000080F0.
  - WIDTH=64: LW on mem=64'h0000_0000_8000_0000 -> 64'hFFFF_FFFF_8000_0000; LWU on the same data -> 64'h0000_0000_8000_0000.
- Ebreak halt: stream addi, ebreak, addi:
  - m_ready_o drops while the ebreak is in W.
  - halt_o=1 from the next cycle; the third instruction is held and not accepted.
  - instret_o=2.
  - resume_i pulse -> RUN; the held instruction is accepted on the following edge.
- Async reset mid-stream: assert rst_n=0 between edges with W valid and instret_o=7 -> all outputs 0 immediately (m_ready_o=1). After release, the first accept retires with instret_o 0->1.
